// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Round-robin arbiter sharing one uart_tx among N_REQ byte
//             producers. One granted byte is carried through a complete
//             serial frame (tx_start -> tx_busy high -> tx_busy low) before
//             the next grant is considered.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int ID_W         = 2,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     ack,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 active,
   output logic                 err
);

   // The timeout counter only has to represent 0 .. BUSY_TIMEOUT-1: the
   // cycle that would make it reach BUSY_TIMEOUT is the abort cycle itself.
   localparam int                CNT_W     = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [ID_W-1:0]   PTR_RESET = ID_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     rr_ptr_nxt;
   logic [CNT_W-1:0]    to_cnt;
   logic [CNT_W-1:0]    to_cnt_nxt;

   logic [N_REQ-1:0]    ack_nxt;
   logic                tx_start_nxt;
   logic [7:0]          tx_data_nxt;
   logic [ID_W-1:0]     grant_id_nxt;
   logic                active_nxt;
   logic                err_nxt;

   logic                any_req;
   logic [ID_W-1:0]     winner;
   logic [7:0]          req_byte [N_REQ];

   // Split the flat data bus into one byte per requester.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_byte
      assign req_byte[gi] = req_data[8*gi +: 8];
   end

   // Index that is 'offset' places after 'base', wrapped modulo N_REQ.
   // base <= N_REQ-1 and offset <= N_REQ, so one conditional subtract
   // is always enough and the sum fits in ID_W+1 bits.
   function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                input int              offset);
      logic [ID_W:0] sum;
      sum = {1'b0, base} + (ID_W+1)'(offset);
      if (sum >= (ID_W+1)'(N_REQ)) begin
         sum = sum - (ID_W+1)'(N_REQ);
      end
      return sum[ID_W-1:0];
   endfunction

   // Round-robin search: walk from the farthest candidate back to the
   // nearest one (pointer+1) so the nearest requesting index is kept.
   always_comb begin : p_rr_search
      any_req = 1'b0;
      winner  = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         if (req[rr_index(rr_ptr, off)]) begin
            any_req = 1'b1;
            winner  = rr_index(rr_ptr, off);
         end
      end
   end

   // Next-state and next-output logic; all outputs are registered copies
   // of the *_nxt values so they change only on clock edges (or reset).
   always_comb begin : p_fsm_next
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      to_cnt_nxt   = to_cnt;
      ack_nxt      = '0;
      tx_start_nxt = 1'b0;
      tx_data_nxt  = tx_data;
      grant_id_nxt = grant_id;
      err_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            // tx_busy is deliberately not looked at here, so a glitch on
            // it between frames has no effect.
            if (any_req) begin
               state_nxt    = S_START;
               rr_ptr_nxt   = winner;
               ack_nxt      = N_REQ'(1) << winner;
               tx_start_nxt = 1'b1;
               tx_data_nxt  = req_byte[winner];
               grant_id_nxt = winner;
            end
         end

         S_START: begin
            to_cnt_nxt = '0;
            state_nxt  = S_WAIT_BUSY;
         end

         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_nxt = S_WAIT_DONE;
            end else if (to_cnt == CNT_LAST) begin
               // This cycle is the BUSY_TIMEOUT-th one without tx_busy.
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end

         S_WAIT_DONE: begin
            if (!tx_busy) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      active_nxt = (state_nxt != S_IDLE);
   end

   // State, pointer and counter registers.
   always_ff @(posedge clk or negedge rst) begin : p_fsm_state
      if (!rst) begin
         state  <= S_IDLE;
         rr_ptr <= PTR_RESET;
         to_cnt <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         to_cnt <= to_cnt_nxt;
      end
   end

   // Output registers; an in-flight frame is simply forgotten on reset.
   always_ff @(posedge clk or negedge rst) begin : p_out_reg
      if (!rst) begin
         ack      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         grant_id <= '0;
         active   <= 1'b0;
         err      <= 1'b0;
      end else begin
         ack      <= ack_nxt;
         tx_start <= tx_start_nxt;
         tx_data  <= tx_data_nxt;
         grant_id <= grant_id_nxt;
         active   <= active_nxt;
         err      <= err_nxt;
      end
   end

endmodule
`default_nettype wire
